// File: rtl/register_file_pkg.sv
// Shared definitions for register_file and other sequential-sweep controllers.
package register_file_pkg;

  // Two-state sweep controller: idle, or walking a pointer across storage.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } sweep_state_e;

endpackage : register_file_pkg

// File: rtl/register_file_if.sv
// Bus bundle between a register_file and its user: one write port, two read ports, clear control.
interface register_file_if #(
  parameter int SIZE  = 16,
  parameter int DEPTH = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [SIZE-1:0]   wrData;
  logic [ADDR_W-1:0] rdAddrA;
  logic [ADDR_W-1:0] rdAddrB;
  logic [SIZE-1:0]   rdDataA;
  logic [SIZE-1:0]   rdDataB;
  logic              validA;
  logic              validB;
  logic              clearReq;
  logic              busy;

  modport master (
    output wrEn, wrAddr, wrData, rdAddrA, rdAddrB, clearReq,
    input  rdDataA, rdDataB, validA, validB, busy
  );

  modport slave (
    input  wrEn, wrAddr, wrData, rdAddrA, rdAddrB, clearReq,
    output rdDataA, rdDataB, validA, validB, busy
  );

endinterface : register_file_if

// File: rtl/register_file_reg_entry.sv
// One storage entry: SIZE-bit data plus a valid flag; sync clear wins over load.
module reg_entry #(
  parameter int SIZE = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            clr_i,
  input  logic [SIZE-1:0] data_i,
  output logic [SIZE-1:0] data_o,
  output logic            valid_o
);

  logic [SIZE-1:0] data_q;
  logic            valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clr_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule : reg_entry

// File: rtl/register_file.sv
// Two-read/one-write register file with optional write forwarding, hardwired-zero entry 0
// and a one-entry-per-cycle clear sweep controller.
module register_file
  import register_file_pkg::*;
#(
  parameter int SIZE      = 16,
  parameter int DEPTH     = 8,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 0
) (
  input logic            clk,
  input logic            rst,
  register_file_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  sweep_state_e      state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q;

  logic              wr_accept;
  logic              fwd_ok;
  logic [DEPTH-1:0]  load;
  logic [DEPTH-1:0]  clr;
  logic [SIZE-1:0]   ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_valid;

  // Sweep controller; busy is registered so it rises the cycle after clearReq is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.clearReq) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr_q == LAST_IDX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_accept = bus.wrEn & ~busy_q;
  assign fwd_ok    = (BYPASS != 0) & wr_accept & ~rst;

  always_comb begin
    load = '0;
    clr  = '0;
    if (wr_accept && !((ZERO_REG0 != 0) && (bus.wrAddr == '0))) begin
      load[bus.wrAddr] = 1'b1;
    end
    if (busy_q) begin
      clr[ptr_q] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    reg_entry #(
      .SIZE(SIZE)
    ) u_entry (
      .clk_i  (clk),
      .rst_i  (rst),
      .load_i (load[i]),
      .clr_i  (clr[i]),
      .data_i (bus.wrData),
      .data_o (ent_data[i]),
      .valid_o(ent_valid[i])
    );
  end

  // Read priority: hardwired entry 0, then forwarded write data, then stored contents.
  always_comb begin
    bus.rdDataA = ent_data[bus.rdAddrA];
    bus.validA  = ent_valid[bus.rdAddrA];
    if (fwd_ok && (bus.rdAddrA == bus.wrAddr)) begin
      bus.rdDataA = bus.wrData;
      bus.validA  = 1'b1;
    end
    if ((ZERO_REG0 != 0) && (bus.rdAddrA == '0)) begin
      bus.rdDataA = '0;
      bus.validA  = 1'b1;
    end
  end

  always_comb begin
    bus.rdDataB = ent_data[bus.rdAddrB];
    bus.validB  = ent_valid[bus.rdAddrB];
    if (fwd_ok && (bus.rdAddrB == bus.wrAddr)) begin
      bus.rdDataB = bus.wrData;
      bus.validB  = 1'b1;
    end
    if ((ZERO_REG0 != 0) && (bus.rdAddrB == '0)) begin
      bus.rdDataB = '0;
      bus.validB  = 1'b1;
    end
  end

  assign bus.busy = busy_q;

endmodule : register_file

// File: tb/tb_register_file.sv
// Bench for register_file: two configurations driven in lockstep and checked against a behavioural model.
module tb_register_file;

  localparam int SIZE  = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            wrEn     = 1'b0;
  logic [AW-1:0]   wrAddr   = '0;
  logic [SIZE-1:0] wrData   = '0;
  logic [AW-1:0]   rdAddrA  = '0;
  logic [AW-1:0]   rdAddrB  = '0;
  logic            clearReq = 1'b0;

  register_file_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus0 ();
  register_file_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus1 ();

  assign bus0.wrEn = wrEn;       assign bus1.wrEn = wrEn;
  assign bus0.wrAddr = wrAddr;   assign bus1.wrAddr = wrAddr;
  assign bus0.wrData = wrData;   assign bus1.wrData = wrData;
  assign bus0.rdAddrA = rdAddrA; assign bus1.rdAddrA = rdAddrA;
  assign bus0.rdAddrB = rdAddrB; assign bus1.rdAddrB = rdAddrB;
  assign bus0.clearReq = clearReq; assign bus1.clearReq = clearReq;

  register_file #(.SIZE(SIZE), .DEPTH(DEPTH), .BYPASS(1), .ZERO_REG0(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  register_file #(.SIZE(SIZE), .DEPTH(DEPTH), .BYPASS(0), .ZERO_REG0(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Reference model: contents, valid flags and the index of the next entry to be swept.
  logic [SIZE-1:0] m_mem [DEPTH];
  logic            m_val [DEPTH];
  bit              m_sweep;
  int unsigned     m_idx;
  bit              cfg_byp  [2] = '{1'b1, 1'b0};
  bit              cfg_zero [2] = '{1'b0, 1'b1};

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_val[i] = 1'b0;
    end
    m_sweep = 1'b0;
    m_idx   = 0;
  endtask

  task automatic exp_read(input int c, input logic [AW-1:0] a,
                          output logic [SIZE-1:0] d, output logic v);
    if (cfg_zero[c] && a == 0) begin
      d = '0; v = 1'b1;
    end else if (!rst && cfg_byp[c] && wrEn && !m_sweep && a == wrAddr) begin
      d = wrData; v = 1'b1;
    end else begin
      d = m_mem[a]; v = m_val[a];
    end
  endtask

  task automatic check_model(input string tag);
    logic [SIZE-1:0] ad, bd, ead, ebd;
    logic av, bv, by, eav, ebv;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        ad = bus0.rdDataA; av = bus0.validA; bd = bus0.rdDataB; bv = bus0.validB; by = bus0.busy;
      end else begin
        ad = bus1.rdDataA; av = bus1.validA; bd = bus1.rdDataB; bv = bus1.validB; by = bus1.busy;
      end
      exp_read(c, rdAddrA, ead, eav);
      exp_read(c, rdAddrB, ebd, ebv);
      chk($sformatf("%s dut%0d rdDataA[%0d]", tag, c, rdAddrA), 32'(ad), 32'(ead));
      chk($sformatf("%s dut%0d validA[%0d]", tag, c, rdAddrA), 32'(av), 32'(eav));
      chk($sformatf("%s dut%0d rdDataB[%0d]", tag, c, rdAddrB), 32'(bd), 32'(ebd));
      chk($sformatf("%s dut%0d validB[%0d]", tag, c, rdAddrB), 32'(bv), 32'(ebv));
      chk($sformatf("%s dut%0d busy", tag, c), 32'(by), 32'(m_sweep && !rst));
    end
  endtask

  // Rising-edge rules: idle accepts the write and may start a sweep; a sweep clears one entry per edge.
  task automatic model_edge();
    if (!m_sweep) begin
      if (wrEn) begin
        m_mem[wrAddr] = wrData;
        m_val[wrAddr] = 1'b1;
      end
      if (clearReq) begin
        m_sweep = 1'b1;
        m_idx   = 0;
      end
    end else begin
      m_mem[m_idx] = '0;
      m_val[m_idx] = 1'b0;
      if (m_idx == DEPTH - 1) m_sweep = 1'b0;
      else m_idx++;
    end
  endtask

  task automatic drive_sample(input logic we, input logic [AW-1:0] wa, input logic [SIZE-1:0] wd,
                              input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic cr,
                              input string tag);
    wrEn = we; wrAddr = wa; wrData = wd; rdAddrA = ra; rdAddrB = rb; clearReq = cr;
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [SIZE-1:0] wd,
                      input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic cr,
                      input string tag);
    drive_sample(we, wa, wd, ra, rb, cr, tag);
    advance();
  endtask

  // Asynchronous reset mid-cycle, with a write and clear request pending to prove they are masked.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    wrEn = 1'b1; wrAddr = 3'd3; wrData = 16'hDEAD; clearReq = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      rdAddrA = AW'(a);
      rdAddrB = AW'(DEPTH - 1 - a);
      #1;
      check_model("in_reset");
    end
    wrEn = 1'b0; clearReq = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_model("post_reset");
  endtask

  task automatic fill(input string tag);
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, AW'(i), SIZE'(16'h1000 + i), AW'(i), AW'((i + 1) % DEPTH), 1'b0, tag);
  endtask

  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [SIZE-1:0] wd;
    logic [AW-1:0]   ra;
    logic [AW-1:0]   rb;
    logic            cr;
    logic [SIZE-1:0] ea;
    logic            eva;
    logic [SIZE-1:0] eb;
    logic            evb;
    logic            ebusy;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit done;

    // Expected values for the BYPASS=1 / ZERO_REG0=0 instance straight after reset.
    tbl[0] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd3, 1'b0, 16'hA5A5, 1'b1, 16'hA5A5, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd4, 1'b0, 16'hA5A5, 1'b1, 16'h0000, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 3'd4, 16'h1234, 3'd4, 3'd3, 1'b0, 16'h1234, 1'b1, 16'hA5A5, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 3'd0, 16'h0000, 3'd4, 3'd5, 1'b0, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 3'd7, 16'hBEEF, 3'd7, 3'd0, 1'b1, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 3'd1, 16'hFFFF, 3'd7, 3'd1, 1'b0, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 1'b1};

    #1;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      drive_sample(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb, tbl[i].cr,
                   $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d rdDataA", i), 32'(bus0.rdDataA), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d validA", i), 32'(bus0.validA), 32'(tbl[i].eva));
      chk($sformatf("tbl%0d rdDataB", i), 32'(bus0.rdDataB), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d validB", i), 32'(bus0.validB), 32'(tbl[i].evb));
      chk($sformatf("tbl%0d busy", i), 32'(bus0.busy), 32'(tbl[i].ebusy));
      advance();
    end

    // Let the sweep started with the BEEF write finish; addr 7 is watched until it clears.
    for (int k = 0; k < 20 && m_sweep; k++)
      step(1'b0, 3'd0, 16'h0, 3'd7, AW'(k % DEPTH), 1'b0, "beef_sweep");
    chk("beef cleared data", 32'(bus0.rdDataA), 32'h0);
    chk("beef cleared valid", 32'(bus0.validA), 32'h0);

    // Full fill then sweep: busy for exactly DEPTH sampled cycles, writes and clearReq ignored.
    fill("fill1");
    step(1'b0, 3'd0, 16'h0, 3'd0, 3'd7, 1'b1, "clear_go");
    cnt  = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      drive_sample(1'b1, AW'($urandom_range(0, DEPTH - 1)), SIZE'($urandom),
                   AW'(k % DEPTH), AW'((k + 3) % DEPTH), (k == 3), "sweep");
      if (bus0.busy) cnt++;
      else done = 1'b1;
      advance();
    end
    chk("busy cycle count", 32'(cnt), 32'(DEPTH));

    // Reset partway through a sweep, then the first write after release must land.
    fill("fill2");
    step(1'b0, 3'd0, 16'h0, 3'd5, 3'd6, 1'b1, "clear_go2");
    for (int k = 0; k < 4; k++)
      step(1'b0, 3'd0, 16'h0, AW'(k), 3'd6, 1'b0, "sweep2");
    do_reset();
    step(1'b1, 3'd2, 16'h0001, 3'd0, 3'd2, 1'b0, "post_rst_wr");
    drive_sample(1'b0, 3'd0, 16'h0, 3'd0, 3'd2, 1'b0, "post_rst_rd");
    chk("post rst rdDataB", 32'(bus0.rdDataB), 32'h0001);
    chk("post rst validB", 32'(bus0.validB), 32'h1);
    advance();

    // No-bypass instance returns old contents in the write cycle; zero-reg instance ignores entry 0.
    drive_sample(1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd0, 1'b0, "nobyp_wr");
    chk("nobyp rdDataA same cycle", 32'(bus1.rdDataA), 32'h0);
    chk("nobyp validA same cycle", 32'(bus1.validA), 32'h0);
    advance();
    drive_sample(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd3, 1'b0, "zero_wr");
    chk("nobyp rdDataB next cycle", 32'(bus1.rdDataB), 32'hA5A5);
    chk("zero0 rdDataA during write", 32'(bus1.rdDataA), 32'h0);
    chk("zero0 validA during write", 32'(bus1.validA), 32'h1);
    advance();
    drive_sample(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, "zero_rd");
    chk("zero0 rdDataA after write", 32'(bus1.rdDataA), 32'h0);
    chk("zero0 validA after write", 32'(bus1.validA), 32'h1);
    chk("byp entry0 after write", 32'(bus0.rdDataA), 32'hFFFF);
    advance();

    // Random traffic with occasional clear requests.
    for (int k = 0; k < 300; k++) begin
      logic [AW-1:0] ra;
      ra = AW'($urandom_range(0, DEPTH - 1));
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), SIZE'($urandom), ra,
           ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, DEPTH - 1)),
           ($urandom_range(0, 19) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_register_file

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter SIZE, default 16, data width in bits of every entry.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of entries (power of two, at least 2).
REQ-003 The block SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-004 The block SHALL have parameter ZERO_REG0, default 0; 1 = entry 0 reads as zero, valid=1, writes ignored.
REQ-005 The block SHALL derive local constant ADDR_W = clog2(DEPTH), not user-settable.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-007 Port clk, input, 1, rising-edge clock.
REQ-008 Port rst, input, 1, asynchronous active-high reset.
REQ-009 Port wrEn, input, 1, write strobe sampled at clk rise.
REQ-010 Port wrAddr, input, ADDR_W, write entry index.
REQ-011 Port wrData, input, SIZE, write data.
REQ-012 Port rdAddrA / rdAddrB, input, ADDR_W each, read indices for ports A and B.
REQ-013 Port rdDataA / rdDataB, output, SIZE each, combinational read data.
REQ-014 Port validA / validB, output, 1 each, addressed entry written since last reset/clear.
REQ-015 Port clearReq, input, 1, pulse requesting a sequential clear sweep.
REQ-016 Port busy, output, 1, high while a clear sweep is in progress.

Function
REQ-017 A write SHALL update entry wrAddr with wrData and set its valid bit at the clk rise where wrEn=1 and busy=0.
REQ-018 Reads SHALL be combinational, zero-latency: rdDataX = entry[rdAddrX], validX = valid[rdAddrX].
REQ-019 With BYPASS=1, wrEn=1, busy=0, rdAddrX==wrAddr (and not ZERO_REG0 entry 0), rdDataX SHALL be wrData and validX 1 in the same cycle.
REQ-020 With BYPASS=0, a read of the written address SHALL return the old contents until the next clk rise.
REQ-021 Both read ports SHALL be independent; identical addresses SHALL return identical data.
REQ-022 The controller SHALL be an FSM with states IDLE and CLEAR.
REQ-023 IDLE -> CLEAR on clk rise with clearReq=1; pointer loads 0; busy rises the next cycle.
REQ-024 In CLEAR, each clk rise SHALL zero data and valid of entry[pointer] and increment pointer.
REQ-025 CLEAR -> IDLE on the rise that clears entry DEPTH-1; sweep lasts exactly DEPTH cycles with busy=1.
REQ-026 Writes while busy=1 SHALL be dropped, not queued.
REQ-027 clearReq while busy=1 SHALL be ignored; no sweep restart.
REQ-028 Simultaneous clearReq=1 and wrEn=1 in IDLE: the write SHALL complete, then the sweep clears it.
REQ-029 Reads during CLEAR SHALL return current contents: cleared entries read 0/valid 0, uncleared entries keep old values.
REQ-030 Pointer width SHALL be ADDR_W; it SHALL not wrap, since the FSM leaves CLEAR at DEPTH-1.

Reset
REQ-031 rst=1 SHALL immediately, without clk, zero all entries, all valid bits and the pointer, and force IDLE.
REQ-032 While rst=1: rdDataA/B=0, validA/B=0 (except ZERO_REG0 entry 0: valid=1), busy=0.
REQ-033 rst during CLEAR SHALL abort the sweep; after release the block SHALL be IDLE with all entries zero.
REQ-034 The first write SHALL be accepted at the first clk rise after rst falls.

Structure
REQ-035 FSM state encoding (IDLE, CLEAR) SHALL live in a shared package, reusable by other sweep controllers.
REQ-036 Each storage entry SHALL be an instance of one natural sub-module, reg_entry: SIZE-bit data plus valid bit, async reset, load and sync-clear inputs.
REQ-037 Write decode, bypass mux and clear controller SHALL reside in register_file.

Verification
REQ-038 Reset then read all addresses -> every rdData=0, valid=0, busy=0.
REQ-039 Write 0xA5A5 to addr 3, rdAddrA=3 same cycle -> BYPASS=1: rdDataA=0xA5A5, validA=1; BYPASS=0: 0x0000, validA=0 until next rise.
REQ-040 Fill all 8 entries with 0x1000+i, pulse clearReq -> busy=1 for exactly 8 cycles; entry k reads 0 from sweep cycle k+1; wrEn during sweep has no effect.
REQ-041 clearReq and write 0xBEEF to addr 7 in the same IDLE cycle -> addr 7 reads 0xBEEF during sweep until cleared, then 0, valid 0.
REQ-042 Assert rst at sweep cycle 4 -> busy=0 at once, all entries 0; write 0x0001 to addr 2 after release -> rdDataB=0x0001, validB=1.
REQ-043 ZERO_REG0=1, write 0xFFFF to addr 0 -> rdDataA=0x0000, validA=1 before and after the write.
